// File: rtl/execute.sv
// Execute stage: single-cycle RV64I ALU plus an iterative RV64M multiply/divide unit.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous, active-high reset
//   dataD     in   decoded bundle from decode (held stable by upstream while stallE=1)
//   flush     in   discard the in-flight instruction, abort any iterative op
//   dataE     out  ctl/dst/pc/wd passed through, result = computed value
//   forwardE  out  forwarding record {wa, result, regwrite}
//   stallE    out  high while an iterative op occupies the stage
//
// Build option: define EXE_FAST_MUL_EN to compute MUL/MULW in one cycle with the
// '*' operator; divide and remainder stay iterative either way.

package execute_pkg;
  parameter int unsigned XLEN = 64;

  typedef enum logic [4:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra, OpSlt, OpSltu,
    OpJal, OpJalr, OpAddw, OpSubw, OpSllw, OpSrlw, OpSraw,
    OpMul, OpMulw, OpDiv, OpDivu, OpRem, OpRemu, OpDivw, OpDivuw, OpRemw, OpRemuw
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    branch;
  } ctl_t;

  typedef struct packed {
    ctl_t            ctl;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] pc;
    logic [4:0]      dst;
  } decode_data_t;

  typedef struct packed {
    ctl_t            ctl;
    logic [4:0]      dst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] result;
  } execute_data_t;

  typedef struct packed {
    logic [4:0]      wa;
    logic [XLEN-1:0] result;
    logic            regwrite;
  } forward_data_t;
endpackage

module execute
  import execute_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  decode_data_t  dataD,
  input  logic          flush,
  output execute_data_t dataE,
  output forward_data_t forwardE,
  output logic          stallE
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Per-operation facts captured at acceptance.
  typedef struct packed {
    logic            mul;
    logic            rem;
    logic            w;
    logic            neg_quo;
    logic            neg_rem;
    logic            corner;
    logic [XLEN-1:0] corner_val;
  } m_info_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  state_e          state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d;   // multiplicand / dividend-quotient shifter
  logic [XLEN-1:0] b_q, b_d;   // multiplier / divisor
  logic [XLEN-1:0] p_q, p_d;   // product accumulator / partial remainder
  logic [XLEN-1:0] res_q, res_d;
  m_info_t         info_q, info_d;

  alu_op_e op;
  logic [XLEN-1:0] srca, srcb;
  assign op   = dataD.ctl.alu_op;
  assign srca = dataD.srca;
  assign srcb = dataD.srcb;

  // ---------------- Decode of M ops ----------------
  logic is_mul, is_div, is_w, is_sgn, is_rem, is_iter;
  assign is_mul = (op == OpMul) || (op == OpMulw);
  assign is_div = op inside {OpDiv, OpDivu, OpRem, OpRemu, OpDivw, OpDivuw, OpRemw, OpRemuw};
  assign is_w   = op inside {OpMulw, OpDivw, OpDivuw, OpRemw, OpRemuw};
  assign is_sgn = op inside {OpDiv, OpRem, OpDivw, OpRemw};
  assign is_rem = op inside {OpRem, OpRemu, OpRemw, OpRemuw};
`ifdef EXE_FAST_MUL_EN
  assign is_iter = is_div;
`else
  assign is_iter = is_mul || is_div;
`endif

  logic accept, kill;
  assign kill   = flush || reset;
  assign accept = (state_q == StIdle) && is_iter && !kill;

  // ---------------- Single-cycle ALU ----------------
  logic [31:0] w_add, w_sub, w_sll, w_srl, w_sra;
  assign w_add = srca[31:0] + srcb[31:0];
  assign w_sub = srca[31:0] - srcb[31:0];
  assign w_sll = srca[31:0] << srcb[4:0];
  assign w_srl = srca[31:0] >> srcb[4:0];
  assign w_sra = $unsigned($signed(srca[31:0]) >>> srcb[4:0]);

`ifdef EXE_FAST_MUL_EN
  logic [XLEN-1:0] fast_mul;
  logic [31:0]     fast_mulw;
  assign fast_mul  = srca * srcb;
  assign fast_mulw = srca[31:0] * srcb[31:0];
`endif

  logic [XLEN-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    unique case (op)
      OpAdd:   alu_res = srca + srcb;
      OpSub:   alu_res = srca - srcb;
      OpAnd:   alu_res = srca & srcb;
      OpOr:    alu_res = srca | srcb;
      OpXor:   alu_res = srca ^ srcb;
      OpSll:   alu_res = srca << srcb[5:0];
      OpSrl:   alu_res = srca >> srcb[5:0];
      OpSra:   alu_res = $unsigned($signed(srca) >>> srcb[5:0]);
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, srca < srcb};
      OpJal,
      OpJalr:  alu_res = dataD.pc + 64'd4;
      OpAddw:  alu_res = sext32(w_add);
      OpSubw:  alu_res = sext32(w_sub);
      OpSllw:  alu_res = sext32(w_sll);
      OpSrlw:  alu_res = sext32(w_srl);
      OpSraw:  alu_res = sext32(w_sra);
`ifdef EXE_FAST_MUL_EN
      OpMul:   alu_res = fast_mul;
      OpMulw:  alu_res = sext32(fast_mulw);
`endif
      default: alu_res = '0;
    endcase
  end

  // ---------------- Operand preparation at acceptance ----------------
  logic [XLEN-1:0] ea, eb, mag_a, mag_b, most_neg;
  logic            sign_a, sign_b, div0, ovf;
  always_comb begin
    ea       = is_w ? (is_sgn ? sext32(srca[31:0]) : {32'b0, srca[31:0]}) : srca;
    eb       = is_w ? (is_sgn ? sext32(srcb[31:0]) : {32'b0, srcb[31:0]}) : srcb;
    sign_a   = is_sgn && ea[XLEN-1];
    sign_b   = is_sgn && eb[XLEN-1];
    mag_a    = sign_a ? -ea : ea;
    mag_b    = sign_b ? -eb : eb;
    most_neg = is_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div0     = is_div && (eb == '0);
    ovf      = is_div && is_sgn && (ea == most_neg) && (eb == '1);
  end

  // ---------------- One iteration step ----------------
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;
  logic [XLEN-1:0] step_a, step_b, step_p;
  always_comb begin
    rem_sh = {p_q, a_q[XLEN-1]};
    diff   = rem_sh - {1'b0, b_q};
    ge     = !diff[XLEN];
    if (info_q.mul) begin
      step_p = b_q[0] ? p_q + a_q : p_q;
      step_a = a_q << 1;
      step_b = b_q >> 1;
    end else begin
      step_p = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      step_a = {a_q[XLEN-2:0], ge};
      step_b = b_q;
    end
  end

  // Final value formed from the last step's outputs so DONE can show it directly.
  logic [XLEN-1:0] q_mag, raw, fin;
  always_comb begin
    q_mag = info_q.w ? {32'b0, step_a[31:0]} : step_a;
    if (info_q.mul)      raw = step_p;
    else if (info_q.rem) raw = info_q.neg_rem ? -step_p : step_p;
    else                 raw = info_q.neg_quo ? -q_mag : q_mag;
    if (info_q.corner) raw = info_q.corner_val;
    fin = info_q.w ? sext32(raw[31:0]) : raw;
  end

  // ---------------- Next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    res_d   = res_q;
    info_d  = info_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          info_d.mul        = is_mul;
          info_d.rem        = is_rem;
          info_d.w          = is_w;
          info_d.neg_quo    = sign_a ^ sign_b;
          info_d.neg_rem    = sign_a;
          info_d.corner     = div0 || ovf;
          info_d.corner_val = div0 ? (is_rem ? ea : '1) : (is_rem ? '0 : ea);
          // Dividend is left-aligned so every step pulls from the MSB.
          a_d     = is_mul ? ea : (is_w ? {mag_a[31:0], 32'b0} : mag_a);
          b_d     = is_mul ? eb : mag_b;
          p_d     = '0;
          cnt_d   = is_w ? 7'd31 : 7'd63;
          state_d = StBusy;
        end
      end
      StBusy: begin
        a_d = step_a;
        b_d = step_b;
        p_d = step_p;
        if (cnt_q == 7'd0) begin
          res_d   = fin;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      res_q   <= '0;
      info_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      res_q   <= res_d;
      info_q  <= info_d;
    end
  end

  // ---------------- Outputs ----------------
  logic busy_now, rw;
  assign busy_now = accept || (state_q == StBusy);
  // Stalled cycles are bubbles downstream: no partial product is ever written or forwarded.
  assign rw       = dataD.ctl.regwrite && !dataD.ctl.branch && !kill && !busy_now;

  always_comb begin
    dataE.ctl          = dataD.ctl;
    dataE.ctl.regwrite = rw;
    if (kill) begin
      dataE.ctl.memread  = 1'b0;
      dataE.ctl.memwrite = 1'b0;
    end
    dataE.dst    = dataD.dst;
    dataE.pc     = dataD.pc;
    dataE.wd     = dataD.wd;
    dataE.result = reset ? '0 : ((state_q == StDone) ? res_q : alu_res);

    forwardE.wa       = dataD.dst;
    forwardE.result   = dataE.result;
    forwardE.regwrite = rw;

    stallE = busy_now && !reset;
  end

endmodule

// File: tb/tb_execute.sv
module tb_execute;
  import execute_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  decode_data_t  dataD;
  execute_data_t dataE;
  forward_data_t forwardE;
  logic          stallE;

  always #5 clk = ~clk;

  execute dut (
    .clk      (clk),
    .reset    (reset),
    .dataD    (dataD),
    .flush    (flush),
    .dataE    (dataE),
    .forwardE (forwardE),
    .stallE   (stallE)
  );

`ifdef EXE_FAST_MUL_EN
  localparam int MulStall  = 0;
  localparam int MulwStall = 0;
`else
  localparam int MulStall  = 65;
  localparam int MulwStall = 33;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    alu_op_e     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] pc;
    logic        rw;
    logic        br;
    logic [63:0] exp;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input alu_op_e op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] pc, input logic rw, input logic br);
    dataD.ctl.alu_op   = op;
    dataD.ctl.regwrite = rw;
    dataD.ctl.memread  = 1'b0;
    dataD.ctl.memwrite = 1'b0;
    dataD.ctl.branch   = br;
    dataD.srca         = a;
    dataD.srcb         = b;
    dataD.wd           = 64'h0;
    dataD.pc           = pc;
    dataD.dst          = 5'd7;
  endtask

  task automatic nop();
    drive(OpAdd, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
  endtask

  // Issue an M op, count stall cycles, then check the DONE-cycle outputs.
  task automatic run_m(input string name, input alu_op_e op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int exp_stall);
    int n;
    n = 0;
    @(posedge clk); #1;
    drive(op, a, b, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    while (stallE && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({name, " stall cycles"}, 64'(n), 64'(exp_stall));
    check({name, " result"}, dataE.result, exp);
    check({name, " fwd regwrite"}, {63'b0, forwardE.regwrite}, 64'd1);
  endtask

  initial begin
    vecs[0]  = '{OpAdd,  64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 1'b1, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    vecs[1]  = '{OpAddw, 64'h7FFF_FFFF, 64'd1, 64'h0, 1'b1, 1'b0,
                 64'hFFFF_FFFF_8000_0000, 1'b1};
    vecs[2]  = '{OpSub,  64'd10, 64'd3, 64'h0, 1'b1, 1'b0, 64'd7, 1'b1};
    vecs[3]  = '{OpAnd,  64'hF0F0, 64'h0FF0, 64'h0, 1'b1, 1'b0, 64'h00F0, 1'b1};
    vecs[4]  = '{OpOr,   64'hF0F0, 64'h0FF0, 64'h0, 1'b1, 1'b0, 64'hFFF0, 1'b1};
    vecs[5]  = '{OpXor,  64'hF0F0, 64'h0FF0, 64'h0, 1'b1, 1'b0, 64'hFF00, 1'b1};
    vecs[6]  = '{OpSll,  64'd1, 64'd65, 64'h0, 1'b1, 1'b0, 64'd2, 1'b1};
    vecs[7]  = '{OpSrl,  64'h8000_0000_0000_0000, 64'd63, 64'h0, 1'b1, 1'b0, 64'd1, 1'b1};
    vecs[8]  = '{OpSra,  64'h8000_0000_0000_0000, 64'd4, 64'h0, 1'b1, 1'b0,
                 64'hF800_0000_0000_0000, 1'b1};
    vecs[9]  = '{OpSlt,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b1, 1'b0, 64'd1, 1'b1};
    vecs[10] = '{OpSltu, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b1, 1'b0, 64'd0, 1'b1};
    vecs[11] = '{OpJal,  64'h0, 64'h0, 64'h1000, 1'b1, 1'b0, 64'h1004, 1'b1};
    vecs[12] = '{OpJalr, 64'h55, 64'h0, 64'h2000, 1'b1, 1'b0, 64'h2004, 1'b1};
    vecs[13] = '{OpSubw, 64'd0, 64'd1, 64'h0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[14] = '{OpSllw, 64'd1, 64'd31, 64'h0, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b1};
    vecs[15] = '{OpSrlw, 64'h8000_0000, 64'd4, 64'h0, 1'b1, 1'b0, 64'h0800_0000, 1'b1};
    vecs[16] = '{OpSraw, 64'h8000_0000, 64'd4, 64'h0, 1'b1, 1'b0,
                 64'hFFFF_FFFF_F800_0000, 1'b1};
    vecs[17] = '{OpSllw, 64'd1, 64'd33, 64'h0, 1'b1, 1'b0, 64'd2, 1'b1};
    vecs[18] = '{OpSub,  64'd5, 64'd5, 64'h0, 1'b1, 1'b1, 64'd0, 1'b0};  // branch

    reset = 1'b1;
    flush = 1'b0;
    nop();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset stallE", {63'b0, stallE}, 64'd0);
    check("reset result", dataE.result, 64'd0);
    check("reset fwd regwrite", {63'b0, forwardE.regwrite}, 64'd0);

    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].rw, vecs[i].br);
      @(negedge clk);
      check($sformatf("vec%0d result", i), dataE.result, vecs[i].exp);
      check($sformatf("vec%0d fwd regwrite", i), {63'b0, forwardE.regwrite},
            {63'b0, vecs[i].exp_rw});
      check($sformatf("vec%0d stallE", i), {63'b0, stallE}, 64'd0);
    end

    // Iterative ops, issued back to back.
    run_m("MUL",    OpMul,  64'h1_0000_0001, 64'd3, 64'h3_0000_0003, MulStall);
    run_m("DIV",    OpDiv,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    run_m("REM",    OpRem,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_m("DIVW",   OpDivw, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33);
    run_m("DIVU0",  OpDivu, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_m("REMU0",  OpRemu, 64'd42, 64'd0, 64'd42, 65);
    run_m("DIVOVF", OpDiv,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 65);
    run_m("REMOVF", OpRem,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
    run_m("MULW",   OpMulw, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MulwStall);
    run_m("DIVUW",  OpDivuw, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, 33);
    run_m("DIVW0",  OpDivw, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 33);

    // Flush ten cycles into a divide.
    @(posedge clk); #1;
    drive(OpDiv, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'h0, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush dataE regwrite", {63'b0, dataE.ctl.regwrite}, 64'd0);
    check("flush fwd regwrite", {63'b0, forwardE.regwrite}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(OpAdd, 64'd2, 64'd3, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("post-flush stallE", {63'b0, stallE}, 64'd0);
    check("post-flush ADD result", dataE.result, 64'd5);
    check("post-flush ADD fwd regwrite", {63'b0, forwardE.regwrite}, 64'd1);

    // Flush arriving together with an M op in IDLE: no BUSY entry.
    @(posedge clk); #1;
    flush = 1'b1;
    drive(OpDivu, 64'd9, 64'd2, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("flush+accept stallE", {63'b0, stallE}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    nop();
    @(negedge clk);
    check("flush+accept next stallE", {63'b0, stallE}, 64'd0);

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    drive(OpMul, 64'h1_0000_0001, 64'd3, 64'h0, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    nop();
    @(negedge clk);
    check("post-reset stallE", {63'b0, stallE}, 64'd0);
    check("post-reset result", dataE.result, 64'd0);
    check("post-reset fwd regwrite", {63'b0, forwardE.regwrite}, 64'd0);
    run_m("MUL again", OpMul, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003, MulStall);

    @(posedge clk); #1;
    nop();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- Execute stage, directly downstream of decode.
- Consumes the decoded bundle (control, srca, srcb, wd, pc, dst) and produces the execute result bundle plus the execute-stage forwarding record.
- Single-cycle integer ALU for RV64I ops; iterative multi-cycle unit for RV64M multiply/divide/remainder.
- Drives stallE, which freezes upstream stages and gates decode's branch resolution while the unit is busy.

Parameters:
- XLEN, 64, datapath width; iterative count is XLEN for 64-bit ops and XLEN/2 for W ops.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dataD  in  decode_data_t  decoded instruction bundle; held stable by upstream while stallE=1
- flush  in  1  discard the in-flight instruction and abort any iterative operation
- dataE  out  execute_data_t  ctl, dst, pc, wd passed through; result = computed value
- forwardE  out  forward_data_t  wa = dst, result, regwrite
- stallE  out  1  high while an iterative op is in progress

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, counter 0, internal accumulators 0, stallE 0, dataE.result 0, forwardE.regwrite 0.
- ALU ops, combinational, zero added latency:
  - ADD/SUB/AND/OR/XOR.
  - SLL/SRL/SRA use srcb[5:0].
  - SLT/SLTU produce 0/1.
  - JAL/JALR: result = pc+4.
  - Branches: regwrite 0.
- W variants: compute on the low 32 bits, shift amount srcb[4:0], then sign-extend bit 31 to XLEN.
- M ops (MUL, DIV, DIVU, REM, REMU and W forms) use the FSM {IDLE, BUSY, DONE}:
  - IDLE with M op and no flush: stallE=1 combinationally. Latch |operands| and sign flags, counter := N-1, go to BUSY.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle, stallE=1. At counter==0 go to DONE, else decrement.
  - DONE: stallE=0, result from the result register (sign-corrected, W-extended), forwardE.regwrite=ctl.regwrite. Go to IDLE next cycle.
  - Total stallE-high cycles = 1+N: 65 for 64-bit, 33 for W. Result is visible in the following cycle.
- Corner results (RISC-V rules), decided in the IDLE cycle; the iteration still runs, so timing is data-independent:
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
  - W forms apply the same rules on 32 bits, then sign-extend.
- MUL returns the low XLEN bits. MULW returns the sign-extended low 32 bits.
- forwardE.regwrite = 0 in IDLE-accept and BUSY cycles, so decode never forwards a partial product. Otherwise it equals ctl.regwrite.
- flush:
  - In any state: next state IDLE, stallE=0 from the next cycle.
  - In the flush cycle itself: dataE.ctl.regwrite, memread and memwrite are forced 0, and forwardE.regwrite is forced 0.
- reset mid-operation: identical to flush, plus the reset values above.
- Simultaneous flush and M-op arrival in IDLE: flush wins; no BUSY entry.
- Back-to-back M ops: the second is accepted in the IDLE cycle after DONE.

Optional Feature:
- EXE_FAST_MUL_EN defined:
  - MUL and MULW use the single-cycle * operator, never enter BUSY, and stallE stays 0.
  - Divide/remainder remain iterative.
- Undefined: all M ops are iterative as above.

Test Plan:
- ADD srca=5, srcb=-7 -> result 0xFFFF_FFFF_FFFF_FFFE same cycle, stallE 0; ADDW srca=0x7FFF_FFFF, srcb=1 -> 0xFFFF_FFFF_8000_0000.
- MUL srca=0x1_0000_0001, srcb=3 -> stallE high for exactly 65 cycles, then result 0x3_0000_0003 with forwardE.regwrite 1 for one cycle; with EXE_FAST_MUL_EN, same result with 0 stall cycles.
- DIV srca=-20, srcb=3 -> quotient -6; REM on the same operands -> -2; DIVW -> 33 stall cycles.
- DIVU by zero srca=42 -> 0xFFFF_FFFF_FFFF_FFFF; REMU -> 42; DIV 0x8000_0000_0000_0000 by -1 -> 0x8000_0000_0000_0000; REM on the same operands -> 0.
- Flush asserted 10 cycles into a DIV -> stallE 0 next cycle, no regwrite emitted; a following ADD completes normally.
- Reset asserted mid-MUL -> all outputs at reset values next cycle; MUL reissued afterwards yields the correct product.
